load_align_unit: RTL and testbench
==================================

# load_align_unit

Parametrised, multi-cycle load unit between the core's memory stage and a request/grant/rvalid data bus. It accepts one load at a time, issues one or two bus-aligned reads, and returns sign- or zero-extended data. Loads that cross a bus-word boundary are split into two bus beats when `MISALIGN_EN=1`. It replaces the purely combinational byte/half/word extender with a handshaked, width-generic unit that supports RV32 and RV64 and reports errors.

## Interface
- `XLEN`, 32: data and bus width; legal values are 32 or 64. `BYTES = XLEN/8`.
- `ADDR_W`, 32: byte-address width.
- `MISALIGN_EN`, 1: 1 splits boundary-crossing loads; 0 reports them as errors.

Ports:
- `clk_i` in 1: single clock; all state updates on the rising edge.
- `rst_ni` in 1: asynchronous, active-low reset.
- `ld_valid_i` in 1: load request valid.
- `ld_ready_o` out 1: unit idle; a request is accepted when `ld_valid_i & ld_ready_o`.
- `ld_addr_i` in `ADDR_W`: byte address.
- `ld_funct3_i` in 3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; when `XLEN=64` also 011 LD and 110 LWU.
- `mem_req_o` out 1: bus read request.
- `mem_addr_o` out `ADDR_W`: bus-aligned address; low `log2(BYTES)` bits are always 0.
- `mem_gnt_i` in 1: request accepted in the cycle where `mem_req_o & mem_gnt_i`.
- `mem_rvalid_i` in 1: read data valid; exactly one per granted request, arriving at least 1 cycle after the grant.
- `mem_rdata_i` in `XLEN`: read data, little-endian.
- `rsp_valid_o` out 1: single-cycle response pulse.
- `rsp_data_o` out `XLEN`: extended load result.
- `rsp_err_o` out 1: illegal `funct3`, or misaligned access with `MISALIGN_EN=0`.

## Operation
- FSM states: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- **IDLE**
  - `ld_ready_o=1`.
  - On accept, register `addr`, `size` (1/2/4/8 bytes), `signed`, and `off = addr[log2(BYTES)-1:0]`.
  - Compute `split = (off + size > BYTES)`.
  - Illegal `funct3`, or `split & !MISALIGN_EN`: go to RESP with `err=1` and `data=0`. No bus access is made.
  - Otherwise go to REQ0.
- **REQ0**
  - `mem_req_o=1`, `mem_addr_o = addr & ~(BYTES-1)`.
  - Address is held stable until grant; on grant go to WAIT0.
- **WAIT0**
  - On `mem_rvalid_i`, capture `beat0`.
  - Go to REQ1 if `split`, else RESP.
- **REQ1 / WAIT1**
  - Same as REQ0/WAIT0 with `mem_addr_o = first address + BYTES`, wrapping modulo 2^`ADDR_W`.
  - Captures `beat1`, then go to RESP.
- **Extraction**
  - `raw = ({beat1, beat0} >> (8*off))`, keeping the low `size` bytes.
  - Sign-extend from bit `8*size-1` when `signed`; zero-extend otherwise.
  - `beat1` is treated as 0 when there is no split.
- **RESP**
  - `rsp_valid_o=1` for exactly one cycle with the registered data/err; return to IDLE.
  - There is no backpressure: the consumer must take the response in that cycle.
- `rsp_data_o` and `rsp_err_o` hold their last value outside RESP. They are meaningful only with `rsp_valid_o`.
- `mem_rvalid_i` and `mem_gnt_i` are ignored in IDLE, REQ*, and RESP states where they are not expected. A stray `rvalid` in IDLE changes nothing.
- Reset (any state):
  - All outputs go to 0 immediately; `ld_ready_o` goes to 1 after deassertion.
  - State returns to IDLE and captured beats clear.
  - An `rvalid` belonging to a pre-reset request that arrives after reset is ignored.

## Timing
- Request accepted at cycle T; `mem_req_o` rises at T+1.
- Aligned load, zero-wait bus (grant at T+1, rvalid at T+2): `rsp_valid_o` at T+3 and `ld_ready_o` at T+4. Throughput is one load per 4 cycles.
- Split load, zero-wait bus: second request at T+3, rvalid at T+4, `rsp_valid_o` at T+5.
- Error response: `rsp_valid_o` at T+1, with `mem_req_o` never asserted.
- Each cycle of grant delay or rvalid delay adds one cycle of latency.
- `ld_ready_o` is 0 from T+1 until the cycle after RESP.

## Test plan
Memory for all cases: word 0x100 = 0x8877_66F5, word 0x104 = 0x4433_2211. `XLEN=32`, `MISALIGN_EN=1` unless stated otherwise.

1. Aligned loads, zero-wait bus:
   - LB 0x100 → 0xFFFF_FFF5; LBU 0x100 → 0x0000_00F5.
   - LH 0x102 → 0xFFFF_8877; LHU 0x102 → 0x0000_8877.
   - LW 0x100 → 0x8877_66F5.
   - Each response arrives at T+3 with exactly one `mem_req_o` at 0x100.
2. Split loads:
   - LW 0x101 → reads 0x100 then 0x104, result 0x1188_7766, `rsp_valid_o` at T+5.
   - LH 0x103 → 0x0000_1188.
   - LH 0x101 → no split, result 0x0000_7766.
3. Bus stalls: grant delayed 3 cycles and rvalid delayed 2 cycles.
   - `mem_req_o`/`mem_addr_o` stay stable until grant.
   - Response arrives at T+8 with correct data.
   - Stray `rvalid` pulses in IDLE have no effect.
4. Errors:
   - `funct3=011` with `XLEN=32` → `rsp_err_o=1`, data 0, `rsp_valid_o` at T+1, no `mem_req_o`.
   - `MISALIGN_EN=0`, LW 0x102 → same error response.
5. `XLEN=64`, memory dword 0x100 = 0x8877_6655_4433_2211:
   - LD 0x100 → the same value.
   - LW 0x104 → 0xFFFF_FFFF_8877_6655; LWU 0x104 → 0x0000_0000_8877_6655.
6. Reset during WAIT1 of a split load:
   - Outputs go to 0 asynchronously.
   - The late `rvalid` after deassertion is ignored.
   - A following LB 0x100 returns 0xFFFF_FFF5 at T+3.

Source files
------------

// File: rtl/load_align_unit.sv
// load_align_unit: one-at-a-time load unit issuing one or two aligned
// bus reads and returning sign/zero-extended data with error reporting.
module load_align_unit #(
  parameter int XLEN        = 32,
  parameter int ADDR_W      = 32,
  parameter bit MISALIGN_EN = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ld_valid_i,
  output logic              ld_ready_o,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic [2:0]        ld_funct3_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [XLEN-1:0]   mem_rdata_i,
  output logic              rsp_valid_o,
  output logic [XLEN-1:0]   rsp_data_o,
  output logic              rsp_err_o
);
  localparam int BYTES = XLEN / 8;
  localparam int OW    = $clog2(BYTES);

  typedef enum logic [2:0] {
    IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [1:0]        sz_q;
  logic              sgn_q;
  logic [OW-1:0]     off_q;
  logic              split_q;
  logic [XLEN-1:0]   beat0_q;

  logic [1:0]        dec_sz;
  logic              dec_sgn;
  logic              dec_ok;
  logic [OW-1:0]     in_off;
  logic [4:0]        span;
  logic              in_split;
  logic              in_err;
  logic              accept;

  always_comb begin
    dec_sz  = 2'd0;
    dec_sgn = 1'b0;
    dec_ok  = 1'b1;
    unique case (1'b1)
      (ld_funct3_i == 3'b000): begin
        dec_sz  = 2'd0;
        dec_sgn = 1'b1;
      end
      (ld_funct3_i == 3'b001): begin
        dec_sz  = 2'd1;
        dec_sgn = 1'b1;
      end
      (ld_funct3_i == 3'b010): begin
        dec_sz  = 2'd2;
        dec_sgn = 1'b1;
      end
      (ld_funct3_i == 3'b100): dec_sz = 2'd0;
      (ld_funct3_i == 3'b101): dec_sz = 2'd1;
      (ld_funct3_i == 3'b011) && (XLEN == 64): begin
        dec_sz  = 2'd3;
        dec_sgn = 1'b1;
      end
      (ld_funct3_i == 3'b110) && (XLEN == 64): dec_sz = 2'd2;
      default: dec_ok = 1'b0;
    endcase
  end

  assign accept   = ld_valid_i && ld_ready_o;
  assign in_off   = ld_addr_i[OW-1:0];
  assign span     = 5'(in_off) + (5'd1 << dec_sz);
  assign in_split = span > 5'(BYTES);
  assign in_err   = !dec_ok || (in_split && !MISALIGN_EN);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = in_err ? RESP : REQ0;
      REQ0:  if (mem_gnt_i) state_d = WAIT0;
      WAIT0: if (mem_rvalid_i) state_d = split_q ? REQ1 : RESP;
      REQ1:  if (mem_gnt_i) state_d = WAIT1;
      WAIT1: if (mem_rvalid_i) state_d = RESP;
      RESP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ld_ready_o  = 1'b0;
    mem_req_o   = 1'b0;
    mem_addr_o  = '0;
    rsp_valid_o = 1'b0;
    unique case (state_q)
      IDLE: ld_ready_o = rst_ni;
      REQ0: begin
        mem_req_o  = 1'b1;
        mem_addr_o = base_q;
      end
      REQ1: begin
        mem_req_o  = 1'b1;
        mem_addr_o = base_q + ADDR_W'(BYTES);
      end
      RESP: rsp_valid_o = 1'b1;
      default: ;
    endcase
  end

  // the final beat is taken straight off the bus so the result is ready in RESP
  logic [XLEN-1:0] lo, hi, raw, ext;
  logic            sb;
  int              nb;

  always_comb begin
    lo  = (state_q == WAIT0) ? mem_rdata_i : beat0_q;
    hi  = (state_q == WAIT1) ? mem_rdata_i : '0;
    raw = XLEN'({hi, lo} >> {off_q, 3'b000});
    nb  = 1 << sz_q;
    unique case (sz_q)
      2'd0:    sb = raw[7];
      2'd1:    sb = raw[15];
      2'd2:    sb = raw[31];
      default: sb = raw[XLEN-1];
    endcase
    ext = '0;
    for (int i = 0; i < BYTES; i++)
      ext[8*i +: 8] = (i < nb) ? raw[8*i +: 8] : {8{sb & sgn_q}};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      base_q     <= '0;
      sz_q       <= '0;
      sgn_q      <= 1'b0;
      off_q      <= '0;
      split_q    <= 1'b0;
      beat0_q    <= '0;
      rsp_data_o <= '0;
      rsp_err_o  <= 1'b0;
    end else begin
      if (state_q == IDLE && accept) begin
        base_q  <= {ld_addr_i[ADDR_W-1:OW], {OW{1'b0}}};
        sz_q    <= dec_sz;
        sgn_q   <= dec_sgn;
        off_q   <= in_off;
        split_q <= in_split;
        beat0_q <= '0;
        if (in_err) begin
          rsp_data_o <= '0;
          rsp_err_o  <= 1'b1;
        end
      end
      if (state_q == WAIT0 && mem_rvalid_i) begin
        beat0_q <= mem_rdata_i;
        if (!split_q) begin
          rsp_data_o <= ext;
          rsp_err_o  <= 1'b0;
        end
      end
      if (state_q == WAIT1 && mem_rvalid_i) begin
        rsp_data_o <= ext;
        rsp_err_o  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit: RV32 split, RV32 no-split
// and RV64 instances behind one shared bus model.
module tb_load_align_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  sel = 2'd0;
  logic        valid_s = 1'b0;
  logic [31:0] addr_s = '0;
  logic [2:0]  f3_s = '0;
  logic        gnt_s = 1'b0;
  logic        rv_s = 1'b0;
  logic [63:0] rdata_s = '0;

  logic        ready [3];
  logic        req [3];
  logic        rspv [3];
  logic        rerr [3];
  logic [31:0] maddr [3];
  logic [63:0] rdat [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int XL = (g == 2) ? 64 : 32;
    localparam bit ME = (g == 1) ? 1'b0 : 1'b1;
    logic [XL-1:0] rd_w;
    load_align_unit #(.XLEN(XL), .ADDR_W(32), .MISALIGN_EN(ME)) u_dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .ld_valid_i  (valid_s && (sel == g)),
      .ld_ready_o  (ready[g]),
      .ld_addr_i   (addr_s),
      .ld_funct3_i (f3_s),
      .mem_req_o   (req[g]),
      .mem_addr_o  (maddr[g]),
      .mem_gnt_i   (gnt_s && (sel == g)),
      .mem_rvalid_i(rv_s && (sel == g)),
      .mem_rdata_i (rdata_s[XL-1:0]),
      .rsp_valid_o (rspv[g]),
      .rsp_data_o  (rd_w),
      .rsp_err_o   (rerr[g])
    );
    assign rdat[g] = 64'(rd_w);
  end

  logic        req_m, rdy_m, rspv_m, rerr_m;
  logic [31:0] maddr_m;
  logic [63:0] rdat_m;
  always_comb begin
    req_m   = req[sel];
    rdy_m   = ready[sel];
    rspv_m  = rspv[sel];
    rerr_m  = rerr[sel];
    maddr_m = maddr[sel];
    rdat_m  = rdat[sel];
  end

  function automatic logic [63:0] mem_rd(logic [31:0] a);
    if (sel == 2'd2)
      return (a == 32'h100) ? 64'h8877_6655_4433_2211 : 64'h0;
    case (a)
      32'h100: return 64'h8877_66F5;
      32'h104: return 64'h4433_2211;
      default: return 64'h0;
    endcase
  endfunction

  int          gnt_dly = 0;
  int          rv_dly = 0;
  logic        stray = 1'b0;
  int          gw = 0;
  int          rvw = 0;
  logic        pend = 1'b0;
  logic        held = 1'b0;
  logic        req_prev = 1'b0;
  logic [31:0] paddr = '0;
  logic [31:0] haddr = '0;
  int          ngnt = 0;
  int          unst = 0;
  logic [31:0] glog [256];

  // grant after gnt_dly waiting cycles, rvalid rv_dly cycles after the first legal slot
  always @(negedge clk) begin
    if (pend) begin
      if (rvw == 0) begin
        rv_s    = 1'b1;
        rdata_s = mem_rd(paddr);
        pend    = 1'b0;
      end else begin
        rv_s = 1'b0;
        rvw--;
      end
    end else begin
      rv_s    = stray;
      rdata_s = 64'hDEAD_BEEF_DEAD_BEEF;
    end
    if (held && (!req_m || maddr_m != haddr)) unst++;
    held  = 1'b0;
    gnt_s = 1'b0;
    if (req_m) begin
      if (!req_prev) gw = gnt_dly;
      if (gw == 0) begin
        gnt_s = 1'b1;
        pend  = 1'b1;
        paddr = maddr_m;
        rvw   = rv_dly;
        glog[ngnt[7:0]] = maddr_m;
        ngnt++;
      end else begin
        gw--;
        held  = 1'b1;
        haddr = maddr_m;
      end
    end
    req_prev = req_m;
  end

  int checks = 0;
  int passes = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic do_load(string tag, logic [1:0] s, logic [31:0] a,
                         logic [2:0] f3, logic [63:0] exp_d, logic exp_e,
                         int exp_lat, int exp_n);
    int lat;
    int nrdy;
    int n0;
    int u0;
    sel = s;
    lat = 0;
    nrdy = 0;
    n0 = ngnt;
    u0 = unst;
    chk({tag, "/ready"}, 64'(rdy_m), 64'd1);
    valid_s = 1'b1;
    addr_s  = a;
    f3_s    = f3;
    @(posedge clk);
    do begin
      @(negedge clk);
      valid_s = 1'b0;
      lat++;
      if (!rspv_m && rdy_m) nrdy++;
    end while (!rspv_m && lat < 40);
    chk({tag, "/lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "/data"}, rdat_m, exp_d);
    chk({tag, "/err"}, 64'(rerr_m), 64'(exp_e));
    chk({tag, "/nreq"}, 64'(ngnt - n0), 64'(exp_n));
    if (exp_n > 0) chk({tag, "/addr0"}, 64'(glog[n0[7:0]]), 64'h100);
    chk({tag, "/busy"}, 64'(nrdy), 64'd0);
    chk({tag, "/stable"}, 64'(unst - u0), 64'd0);
    @(negedge clk);
    chk({tag, "/ready_after"}, 64'(rdy_m), 64'd1);
  endtask

  initial begin
    int k;
    int bad;
    #1;
    chk("rst/ready", 64'(rdy_m), 64'd0);
    chk("rst/req", 64'(req_m), 64'd0);
    chk("rst/rspv", 64'(rspv_m), 64'd0);
    chk("rst/data", rdat_m, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_load("lb", 2'd0, 32'h100, 3'b000, 64'hFFFF_FFF5, 1'b0, 3, 1);
    do_load("lbu", 2'd0, 32'h100, 3'b100, 64'h0000_00F5, 1'b0, 3, 1);
    do_load("lh", 2'd0, 32'h102, 3'b001, 64'hFFFF_8877, 1'b0, 3, 1);
    do_load("lhu", 2'd0, 32'h102, 3'b101, 64'h0000_8877, 1'b0, 3, 1);
    do_load("lw", 2'd0, 32'h100, 3'b010, 64'h8877_66F5, 1'b0, 3, 1);

    do_load("lw_split", 2'd0, 32'h101, 3'b010, 64'h1188_7766, 1'b0, 5, 2);
    chk("lw_split/addr1", 64'(glog[(ngnt - 1) & 255]), 64'h104);
    do_load("lh_split", 2'd0, 32'h103, 3'b001, 64'h0000_1188, 1'b0, 5, 2);
    do_load("lh_nosplit", 2'd0, 32'h101, 3'b001, 64'h0000_7766, 1'b0, 3, 1);

    gnt_dly = 3;
    rv_dly  = 2;
    do_load("stall", 2'd0, 32'h100, 3'b010, 64'h8877_66F5, 1'b0, 8, 1);
    gnt_dly = 0;
    rv_dly  = 0;

    stray = 1'b1;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rspv_m || !rdy_m) bad++;
    end
    stray = 1'b0;
    chk("stray/idle", 64'(bad), 64'd0);
    chk("stray/hold", rdat_m, 64'h8877_66F5);

    do_load("err_f3", 2'd0, 32'h100, 3'b011, 64'h0, 1'b1, 1, 0);
    do_load("err_mis", 2'd1, 32'h102, 3'b010, 64'h0, 1'b1, 1, 0);

    do_load("ld64", 2'd2, 32'h100, 3'b011, 64'h8877_6655_4433_2211, 1'b0, 3, 1);
    do_load("lw64", 2'd2, 32'h104, 3'b010, 64'hFFFF_FFFF_8877_6655, 1'b0, 3, 1);
    do_load("lwu64", 2'd2, 32'h104, 3'b110, 64'h0000_0000_8877_6655, 1'b0, 3, 1);

    do_load("pre_rst", 2'd0, 32'h101, 3'b001, 64'h0000_7766, 1'b0, 3, 1);
    rv_dly = 6;
    k = ngnt;
    valid_s = 1'b1;
    addr_s  = 32'h101;
    f3_s    = 3'b010;
    @(posedge clk);
    @(negedge clk);
    valid_s = 1'b0;
    bad = 0;
    while (ngnt - k < 2 && bad < 20) begin
      @(negedge clk);
      bad++;
    end
    chk("rst_mid/second_req", 64'(ngnt - k), 64'd2);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid/req", 64'(req_m), 64'd0);
    chk("rst_mid/addr", 64'(maddr_m), 64'd0);
    chk("rst_mid/ready", 64'(rdy_m), 64'd0);
    chk("rst_mid/rspv", 64'(rspv_m), 64'd0);
    chk("rst_mid/data", rdat_m, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_mid/ready_after", 64'(rdy_m), 64'd1);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rspv_m || !rdy_m) bad++;
    end
    chk("rst_mid/late_rvalid", 64'(bad), 64'd0);
    chk("rst_mid/pend_done", 64'(pend), 64'd0);
    rv_dly = 0;
    do_load("post_rst_lb", 2'd0, 32'h100, 3'b000, 64'hFFFF_FFF5, 1'b0, 3, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
